// File: rtl/pc_sequencer_pkg.sv
// Shared control encodings: sequencer states, trap cause codes and next-PC op codes.
package pc_sequencer_pkg;

  localparam int XLEN    = 32;
  localparam int CAUSE_W = 4;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } seq_state_e;

  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 4'd0;

  // Op codes consumed by the external next-PC unit.
  typedef enum logic [1:0] {
    NPC_PC4    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JREG   = 2'd3
  } npc_op_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the pipeline / next-PC unit (master) and the PC sequencer (slave).
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic               stall;
  logic [XLEN-1:0]    npc;
  logic               exce_req;
  logic [CAUSE_W-1:0] exce_cause;
  logic [XLEN-1:0]    exce_epc;
  logic               mret;

  logic [XLEN-1:0]    pc;
  logic               exce;
  logic [XLEN-1:0]    exce_pc;
  logic               flush;
  logic [XLEN-1:0]    mepc;
  logic [CAUSE_W-1:0] mcause;
  logic               busy;

  modport master (
    output stall, npc, exce_req, exce_cause, exce_epc, mret,
    input  pc, exce, exce_pc, flush, mepc, mcause, busy
  );

  modport slave (
    input  stall, npc, exce_req, exce_cause, exce_epc, mret,
    output pc, exce, exce_pc, flush, mepc, mcause, busy
  );

endinterface

// File: rtl/pc_sequencer.sv
// PC register plus a RUN/TRAP/RET sequencer that redirects the external next-PC unit
// on exceptions, misaligned targets and trap returns.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] MTVEC    = 32'h0000_0100
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  seq_state_e         state_reg,  state_next;
  logic [XLEN-1:0]    pc_reg,     pc_next;
  logic [XLEN-1:0]    mepc_reg,   mepc_next;
  logic [CAUSE_W-1:0] mcause_reg, mcause_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_RUN;
      pc_reg     <= RESET_PC;
      mepc_reg   <= '0;
      mcause_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      mepc_reg   <= mepc_next;
      mcause_reg <= mcause_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    mepc_next   = mepc_reg;
    mcause_next = mcause_reg;
    bus.exce    = 1'b0;
    bus.exce_pc = '0;
    bus.flush   = 1'b0;

    case (state_reg)
      ST_RUN: begin
        // An exception request wins over a simultaneous mret, which is dropped.
        if (bus.exce_req) begin
          mepc_next   = bus.exce_epc;
          mcause_next = bus.exce_cause;
          state_next  = ST_TRAP;
        end else if (is_misaligned(bus.npc)) begin
          mepc_next   = pc_reg;
          mcause_next = CAUSE_MISALIGN;
          state_next  = ST_TRAP;
        end else if (bus.mret) begin
          state_next  = ST_RET;
        end else if (!bus.stall) begin
          pc_next     = bus.npc;
        end
      end
      ST_TRAP: begin
        bus.exce    = 1'b1;
        bus.exce_pc = MTVEC;
        bus.flush   = 1'b1;
        pc_next     = bus.npc;
        state_next  = ST_RUN;
      end
      ST_RET: begin
        bus.exce    = 1'b1;
        bus.exce_pc = mepc_reg;
        bus.flush   = 1'b1;
        pc_next     = bus.npc;
        state_next  = ST_RUN;
      end
      default: begin
        state_next  = ST_RUN;
      end
    endcase
  end

  assign bus.pc     = pc_reg;
  assign bus.mepc   = mepc_reg;
  assign bus.mcause = mcause_reg;
  assign bus.busy   = (state_reg != ST_RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer with a simple pc+4 next-PC unit model.
module tb_pc_sequencer;

  localparam int S_PC      = 0;
  localparam int S_BUSY    = 1;
  localparam int S_EXCE    = 2;
  localparam int S_EXCE_PC = 3;
  localparam int S_FLUSH   = 4;
  localparam int S_MEPC    = 5;
  localparam int S_MCAUSE  = 6;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  logic saw_22;
  exp_t q[$];

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .MTVEC    (32'h0000_0100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectation for the state visible after the next rising edge.
  task automatic e(input int sig, input logic [31:0] val, input string nm);
    exp_t x;
    x.cyc = cyc + 1;
    x.sig = sig;
    x.val = val;
    x.nm  = nm;
    q.push_back(x);
  endtask

  // Advance one cycle, then let the next-PC unit model respond to the new outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.npc = bus.exce ? bus.exce_pc : bus.pc + 32'd4;
  endtask

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    exp_t        x;
    logic [31:0] act;
    total  = 0;
    bad    = 0;
    saw_22 = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.pc == 32'h22) saw_22 = 1'b1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        x = q.pop_front();
        case (x.sig)
          S_PC:      act = bus.pc;
          S_BUSY:    act = {31'd0, bus.busy};
          S_EXCE:    act = {31'd0, bus.exce};
          S_EXCE_PC: act = bus.exce_pc;
          S_FLUSH:   act = {31'd0, bus.flush};
          S_MEPC:    act = bus.mepc;
          S_MCAUSE:  act = {28'd0, bus.mcause};
          default:   act = 32'hxxxx_xxxx;
        endcase
        total++;
        if (x.cyc != cyc || act !== x.val) begin
          bad++;
          $display("FAIL %s cyc=%0d due=%0d got=%h want=%h", x.nm, cyc, x.cyc, act, x.val);
        end else begin
          $display("check %s cyc=%0d value=%h ok", x.nm, cyc, act);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.stall      = 1'b0;
    bus.npc        = 32'h0;
    bus.exce_req   = 1'b0;
    bus.exce_cause = 4'd0;
    bus.exce_epc   = 32'h0;
    bus.mret       = 1'b0;
    repeat (2) tick();

    // Reset state
    e(S_PC, 32'h0, "rst_pc");
    e(S_BUSY, 32'h0, "rst_busy");
    e(S_EXCE, 32'h0, "rst_exce");
    e(S_FLUSH, 32'h0, "rst_flush");
    e(S_EXCE_PC, 32'h0, "rst_exce_pc");
    e(S_MEPC, 32'h0, "rst_mepc");
    e(S_MCAUSE, 32'h0, "rst_mcause");
    tick();
    rst = 1'b0;

    // Sequential fetch
    e(S_PC, 32'h4, "run_pc4");
    e(S_BUSY, 32'h0, "run_busy");
    tick();
    e(S_PC, 32'h8, "run_pc8");
    tick();

    // Stall holds pc for two cycles
    bus.stall = 1'b1;
    e(S_PC, 32'h8, "stall_1");
    tick();
    e(S_PC, 32'h8, "stall_2");
    tick();
    bus.stall = 1'b0;
    e(S_PC, 32'hC, "after_stall");
    tick();

    // External exception
    bus.exce_req   = 1'b1;
    bus.exce_cause = 4'd2;
    bus.exce_epc   = 32'h10;
    e(S_BUSY, 32'h1, "trap_busy");
    e(S_FLUSH, 32'h1, "trap_flush");
    e(S_EXCE, 32'h1, "trap_exce");
    e(S_EXCE_PC, 32'h100, "trap_target");
    e(S_PC, 32'hC, "trap_hold_pc");
    tick();
    // stall/mret asserted during TRAP must be ignored
    bus.exce_req = 1'b0;
    bus.stall    = 1'b1;
    bus.mret     = 1'b1;
    e(S_PC, 32'h100, "trap_pc_mtvec");
    e(S_MEPC, 32'h10, "trap_mepc");
    e(S_MCAUSE, 32'h2, "trap_mcause");
    e(S_BUSY, 32'h0, "trap_back_run");
    tick();

    // Trap return (mret still high)
    bus.stall = 1'b0;
    e(S_BUSY, 32'h1, "ret_busy");
    e(S_EXCE_PC, 32'h10, "ret_target");
    e(S_FLUSH, 32'h1, "ret_flush");
    e(S_MEPC, 32'h10, "ret_mepc_keep");
    e(S_MCAUSE, 32'h2, "ret_mcause_keep");
    tick();
    bus.mret = 1'b0;
    e(S_PC, 32'h10, "ret_pc");
    e(S_BUSY, 32'h0, "ret_back_run");
    tick();

    for (int i = 1; i <= 4; i++) begin
      e(S_PC, 32'h10 + 32'(4 * i), "walk_pc");
      tick();
    end

    // Misaligned target from pc=0x20
    bus.npc = 32'h22;
    e(S_BUSY, 32'h1, "mis_busy");
    e(S_MCAUSE, 32'h0, "mis_mcause");
    e(S_MEPC, 32'h20, "mis_mepc");
    e(S_PC, 32'h20, "mis_hold_pc");
    tick();
    e(S_PC, 32'h100, "mis_pc_mtvec");
    tick();

    // npc taken verbatim, including wrap-around
    bus.npc = 32'hFFFF_FFFC;
    e(S_PC, 32'hFFFF_FFFC, "wrap_top");
    tick();
    e(S_PC, 32'h0, "wrap_zero");
    tick();
    e(S_PC, 32'h4, "wrap_next");
    tick();

    // exce_req + mret together -> trap only; reset during TRAP aborts
    bus.exce_req   = 1'b1;
    bus.mret       = 1'b1;
    bus.exce_cause = 4'd5;
    bus.exce_epc   = 32'h44;
    e(S_BUSY, 32'h1, "both_busy");
    e(S_EXCE_PC, 32'h100, "both_trap_target");
    e(S_MEPC, 32'h44, "both_mepc");
    e(S_MCAUSE, 32'h5, "both_mcause");
    tick();
    bus.exce_req = 1'b0;
    bus.mret     = 1'b0;
    rst          = 1'b1;
    e(S_PC, 32'h0, "rst_trap_pc");
    e(S_MEPC, 32'h0, "rst_trap_mepc");
    e(S_MCAUSE, 32'h0, "rst_trap_mcause");
    e(S_BUSY, 32'h0, "rst_trap_busy");
    e(S_FLUSH, 32'h0, "rst_trap_flush");
    tick();
    rst = 1'b0;
    e(S_PC, 32'h4, "post_rst_pc");
    e(S_BUSY, 32'h0, "post_rst_no_ret");
    tick();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    total++;
    if (saw_22) begin
      bad++;
      $display("FAIL pc_never_22 got=seen want=never");
    end else begin
      $display("check pc_never_22 ok");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
